data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Multi-cycle data-memory responder serving requests from the MEM pipeline stage.
//   Accepts address, write data, read/write enables and a transfer size.
//   Returns read data and a one-cycle response pulse after a fixed LATENCY.
//   Asserts busy so the pipeline can stall while a request is outstanding.
// PARAMETERS
//   DEPTH_BYTES  1024  byte capacity of the backing array (power of two, >= 8)
//   LATENCY      2     cycles from the accepting edge to the resp_valid cycle (>= 1)
// PORTS
//   clk              in   1   single clock; all state changes on its rising edge
//   reset_n          in   1   asynchronous reset, active-low
//   address          in   64  byte address of the request
//   read_enable      in   1   read request
//   write_enable     in   1   write request
//   write_data       in   64  write data, little-endian; byte 0 goes to address
//   xfer_size        in   4   bytes to transfer: 1, 2, 4 or 8
//   read_data        out  64  read result, zero-extended, little-endian
//   resp_valid       out  1   one-cycle pulse: request complete
//   busy             out  1   request outstanding; new requests are ignored
//   err              out  1   with resp_valid: request rejected, no memory effect
// BEHAVIOUR
//   Reset (reset_n=0, async):
//     - read_data=0, resp_valid=0, busy=0, err=0; FSM goes to IDLE; counter=0.
//     - Array contents are not cleared.
//     - Reset mid-request aborts it: a pending write is discarded, no resp_valid.
//   FSM states: IDLE, WAIT.
//     - IDLE, with (read_enable|write_enable) at a rising edge:
//       latch address, write_data, xfer_size and type; busy<=1; counter<=LATENCY-1; go to WAIT.
//     - WAIT, counter!=0: counter decrements.
//     - WAIT, counter==0: at the next edge, perform the access; resp_valid<=1; busy<=0; go to IDLE.
//     - resp_valid is high for exactly one cycle, LATENCY cycles after the accepting edge.
//       During that cycle the FSM is in IDLE, so a request present then is accepted at the next edge.
//       Back-to-back throughput is one request per LATENCY+1 cycles.
//     - Enables are ignored while busy=1; the requester holds them until busy drops.
//   Legality, checked on the latched request:
//     - xfer_size not in {1,2,4,8}
//     - address % xfer_size != 0 (misaligned)
//     - address + xfer_size > DEPTH_BYTES (upper address bits included)
//     - read_enable and write_enable both set
//     Any of these: err=1 with resp_valid, no array write, read_data unchanged.
//   Legal write: bytes [address .. address+xfer_size-1] <= write_data[8*xfer_size-1:0].
//     The write is committed at the response edge; other bytes are untouched.
//   Legal read: read_data <= zero-extend of those bytes; err=0.
//     read_data holds its value until the next legal read response.
//   Legal write response: err=0, read_data unchanged.
//   err is cleared on the cycle after resp_valid.
// TESTING
//   1. LATENCY=2: write addr 0x10, size 8, data 0x1122334455667788; then read 0x10 size 8
//      -> resp_valid exactly 2 cycles after each accept; read_data=0x1122334455667788, err=0.
//   2. After test 1: read 0x12 size 2 -> 0x0000000000005566; read 0x17 size 1 -> 0x11.
//   3. Write 0x14 size 4, data 0xFFFFFFFFAABBCCDD -> bytes 0x14..0x17 change only;
//      read 0x10 size 8 -> 0xAABBCCDD55667788.
//   4. Read 0x13 size 4; write 0x3FC size 8; xfer_size=3; both enables set
//      -> each gives err=1 with resp_valid; array and read_data unchanged.
//   5. Assert enables every cycle -> accepts spaced LATENCY+1 cycles apart;
//      requests while busy=1 are not executed.
//   6. Drop reset_n during WAIT of a write to 0x20 -> outputs 0 immediately, no resp_valid;
//      a later read of 0x20 returns the prior contents.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle byte-addressed data memory for the MEM stage: one request at a time,
// response pulse a fixed LATENCY after acceptance, busy while outstanding.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] address,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [63:0] write_data,
    input  logic [3:0]  xfer_size,
    output logic [63:0] read_data,
    output logic        resp_valid,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [63:0]   addr_q;
    logic [63:0]   wdata_q;
    logic [3:0]    size_q;
    logic          rd_q;
    logic          wr_q;
    logic [63:0]   read_data_q;
    logic          resp_valid_q;
    logic          busy_q;
    logic          err_q;

    logic [7:0]    mem [DEPTH_BYTES];

    logic          sizeOk;
    logic [2:0]    alignMask;
    logic          misaligned;
    logic [64:0]   endAddr;
    logic          overflow;
    logic          legal;
    logic          fire;
    logic [AW-1:0] idx;
    logic [63:0]   readBytes_d;

    // Legality is judged on the latched request; the full 64-bit address takes part
    // so upper address bits cannot alias into the array.
    assign sizeOk     = size_q inside {4'd1, 4'd2, 4'd4, 4'd8};
    assign alignMask  = size_q[2:0] - 3'd1;
    assign misaligned = (addr_q[2:0] & alignMask) != 3'd0;
    assign endAddr    = {1'b0, addr_q} + {61'd0, size_q};
    assign overflow   = endAddr > 65'(DEPTH_BYTES);
    assign legal      = sizeOk && !misaligned && !overflow && !(rd_q && wr_q);
    assign fire       = (state_q == WAIT) && (cnt_q == '0);
    assign idx        = addr_q[AW-1:0];

    always_comb begin
        readBytes_d = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < size_q) begin
                readBytes_d[8*i +: 8] = mem[idx + AW'(i)];
            end
        end
    end

    // The array has no reset; an aborted request never reaches fire since state_q is IDLE.
    always_ff @(posedge clk) begin
        if (fire && legal && wr_q) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < size_q) begin
                    mem[idx + AW'(i)] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            read_data_q  <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (read_enable || write_enable) begin
                        addr_q  <= address;
                        wdata_q <= write_data;
                        size_q  <= xfer_size;
                        rd_q    <= read_enable;
                        wr_q    <= write_enable;
                        busy_q  <= 1'b1;
                        cnt_q   <= CW'(LATENCY - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        resp_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                        err_q        <= !legal;
                        state_q      <= IDLE;
                        if (legal && rd_q) begin
                            read_data_q <= readBytes_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_data  = read_data_q;
    assign resp_valid = resp_valid_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a cycle-numbered transaction model is
// compared every cycle, and literal expectations pin the model on key requests.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk;
    logic        reset_n;
    logic [63:0] address;
    logic        read_enable;
    logic        write_enable;
    logic [63:0] write_data;
    logic [3:0]  xfer_size;
    logic [63:0] read_data;
    logic        resp_valid;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .write_data   (write_data),
        .xfer_size    (xfer_size),
        .read_data    (read_data),
        .resp_valid   (resp_valid),
        .busy         (busy),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: a request accepted on edge N completes on edge N+LAT.
    logic [7:0]  mMem [DEPTH];
    logic [63:0] mReadData = '0;
    logic        mResp = 1'b0;
    logic        mBusy = 1'b0;
    logic        mErr  = 1'b0;
    bit          pending = 1'b0;
    longint      cyc = 0;
    longint      dueCycle = 0;
    logic [63:0] pAddr, pData;
    logic [3:0]  pSize;
    logic        pRd, pWr;

    function automatic bit isLegal(input logic rd, input logic wr, input logic [63:0] a, input logic [3:0] s);
        if (!(s == 1 || s == 2 || s == 4 || s == 8)) return 1'b0;
        if (a % 64'(s) != 0) return 1'b0;
        if (a >= 64'(DEPTH) || a + 64'(s) > 64'(DEPTH)) return 1'b0;
        if (rd && wr) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge reset_n) begin
        pending   = 1'b0;
        mReadData = '0;
        mResp     = 1'b0;
        mBusy     = 1'b0;
        mErr      = 1'b0;
    end

    always @(posedge clk) begin
        if (reset_n === 1'b1) begin
            cyc++;
            mResp = 1'b0;
            mErr  = 1'b0;
            if (pending) begin
                if (cyc == dueCycle) begin
                    pending = 1'b0;
                    mResp   = 1'b1;
                    mBusy   = 1'b0;
                    if (!isLegal(pRd, pWr, pAddr, pSize)) begin
                        mErr = 1'b1;
                    end else if (pWr) begin
                        for (int i = 0; i < int'(pSize); i++) mMem[int'(pAddr) + i] = pData[8*i +: 8];
                    end else begin
                        mReadData = '0;
                        for (int i = 0; i < int'(pSize); i++) mReadData[8*i +: 8] = mMem[int'(pAddr) + i];
                    end
                end
            end else if (read_enable || write_enable) begin
                pending  = 1'b1;
                dueCycle = cyc + LAT;
                pAddr = address; pData = write_data; pSize = xfer_size;
                pRd = read_enable; pWr = write_enable;
                mBusy = 1'b1;
            end
        end
    end

    bit compareOn = 1'b0;
    always @(negedge clk) begin
        if (compareOn) begin
            checkOutput("model_resp_valid", 64'(resp_valid), 64'(mResp));
            checkOutput("model_busy", 64'(busy), 64'(mBusy));
            checkOutput("model_err", 64'(err), 64'(mErr));
            checkOutput("model_read_data", read_data, mReadData);
        end
    end

    // Presents one request for a single cycle, then waits for its response.
    task automatic applyStimulus(input string name, input logic rd, input logic wr,
                                 input logic [63:0] addr, input logic [63:0] data,
                                 input logic [3:0] size, input logic [63:0] expData,
                                 input logic expErr);
        int k;
        @(negedge clk);
        read_enable = rd; write_enable = wr; address = addr; write_data = data; xfer_size = size;
        @(negedge clk);
        read_enable = 1'b0; write_enable = 1'b0;
        k = 0;
        while (resp_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput({name, "_latency"}, 64'(k), 64'(LAT));
        checkOutput({name, "_data"}, read_data, expData);
        checkOutput({name, "_err"}, 64'(err), 64'(expErr));
        @(negedge clk);
        checkOutput({name, "_pulse_end"}, 64'({resp_valid, err}), 64'd0);
    endtask

    int pulses;

    initial begin
        reset_n = 1'b1; read_enable = 1'b0; write_enable = 1'b0;
        address = '0; write_data = '0; xfer_size = 4'd0;
        #1 reset_n = 1'b0;
        #20 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_state", {read_data[60:0], resp_valid, busy, err}, 64'd0);
        compareOn = 1'b1;

        applyStimulus("t1_write", 1'b0, 1'b1, 64'h10, 64'h1122334455667788, 4'd8, 64'h0, 1'b0);
        applyStimulus("t1_read", 1'b1, 1'b0, 64'h10, 64'h0, 4'd8, 64'h1122334455667788, 1'b0);
        applyStimulus("t2_read_h", 1'b1, 1'b0, 64'h12, 64'h0, 4'd2, 64'h5566, 1'b0);
        applyStimulus("t2_read_b", 1'b1, 1'b0, 64'h17, 64'h0, 4'd1, 64'h11, 1'b0);
        applyStimulus("t3_write", 1'b0, 1'b1, 64'h14, 64'hFFFFFFFFAABBCCDD, 4'd4, 64'h11, 1'b0);
        applyStimulus("t3_read", 1'b1, 1'b0, 64'h10, 64'h0, 4'd8, 64'hAABBCCDD55667788, 1'b0);

        applyStimulus("t4_misalign", 1'b1, 1'b0, 64'h13, 64'h0, 4'd4, 64'hAABBCCDD55667788, 1'b1);
        applyStimulus("t4_oob_write", 1'b0, 1'b1, 64'h3FC, 64'h0, 4'd8, 64'hAABBCCDD55667788, 1'b1);
        applyStimulus("t4_size3", 1'b1, 1'b0, 64'h10, 64'h0, 4'd3, 64'hAABBCCDD55667788, 1'b1);
        applyStimulus("t4_both", 1'b1, 1'b1, 64'h10, 64'h0, 4'd8, 64'hAABBCCDD55667788, 1'b1);
        applyStimulus("t4_end", 1'b1, 1'b0, 64'h400, 64'h0, 4'd1, 64'hAABBCCDD55667788, 1'b1);
        applyStimulus("t4_upper", 1'b0, 1'b1, 64'h1_0000_0010, 64'h0, 4'd8, 64'hAABBCCDD55667788, 1'b1);
        applyStimulus("t4_last_ok", 1'b0, 1'b1, 64'h3F8, 64'h0102030405060708, 4'd8, 64'hAABBCCDD55667788, 1'b0);
        applyStimulus("t4_reread", 1'b1, 1'b0, 64'h10, 64'h0, 4'd8, 64'hAABBCCDD55667788, 1'b0);
        applyStimulus("t4_last_rd", 1'b1, 1'b0, 64'h3FF, 64'h0, 4'd1, 64'h01, 1'b0);

        // Continuous requests: accepts on edges 1, 4, 7 and responses on 3, 6, 9.
        @(negedge clk);
        read_enable = 1'b1; address = 64'h10; xfer_size = 4'd8;
        pulses = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) pulses++;
        end
        read_enable = 1'b0;
        checkOutput("t5_pulse_count", 64'(pulses), 64'd3);
        @(negedge clk);
        checkOutput("t5_idle_after", 64'({resp_valid, busy}), 64'd0);

        applyStimulus("t6_prior", 1'b0, 1'b1, 64'h20, 64'h0123456789ABCDEF, 4'd8, 64'hAABBCCDD55667788, 1'b0);
        @(negedge clk);
        write_enable = 1'b1; address = 64'h20; write_data = 64'hDEADBEEFCAFEF00D; xfer_size = 4'd8;
        @(negedge clk);
        write_enable = 1'b0;
        checkOutput("t6_busy_before", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1 checkOutput("t6_async_clear", {read_data[60:0], resp_valid, busy, err}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) pulses++;
        end
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) pulses++;
        end
        checkOutput("t6_no_resp", 64'(pulses), 64'd0);
        applyStimulus("t6_read", 1'b1, 1'b0, 64'h20, 64'h0, 4'd8, 64'h0123456789ABCDEF, 1'b0);

        compareOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
